// File: rtl/laser_cover_opt.sv
// laser_cover_opt: two-circle coverage optimiser; LASER_EARLY_EXIT_EN stops after any scan covering all N points
module laser_cover_opt #(
  parameter int CW       = 4,
  parameter int N        = 40,
  parameter int R2       = 16,
  parameter int MAX_ITER = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [CW-1:0]            X,
  input  logic [CW-1:0]            Y,
  output logic [CW-1:0]            C1X,
  output logic [CW-1:0]            C1Y,
  output logic [CW-1:0]            C2X,
  output logic [CW-1:0]            C2Y,
  output logic [$clog2(N+1)-1:0]   COVER,
  output logic                     DONE
);
  localparam int AW = 2 * CW;
  localparam int PW = $clog2(N);
  localparam int SW = $clog2(N + 1);
  localparam logic [31:0] R2U = R2;

  typedef enum logic [2:0] {LOAD, SCAN1, SCAN2, CHECK, OUT} state_t;

  state_t          st;
  logic [CW-1:0]   px [N];
  logic [CW-1:0]   py [N];
  logic [PW-1:0]   k, pi;
  logic [AW-1:0]   cand, bc;
  logic [SW-1:0]   acc, best, sc, prev, tot;
  logic            bv, fin, hit, last_p, upd;
  logic [CW-1:0]   c1x, c1y, c2x, c2y;
  logic [CW-1:0]   cx, cy, fx, fy, qx, qy;
  logic [3:0]      pass;

  // Edge-clamped squared distance test; no wrap-around across the grid
  function automatic logic covers(input logic [CW-1:0] ax, input logic [CW-1:0] ay,
                                  input logic [CW-1:0] bx, input logic [CW-1:0] by);
    logic [AW-1:0] dx;
    logic [AW-1:0] dy;
    dx = AW'(ax > bx ? ax - bx : bx - ax);
    dy = AW'(ay > by ? ay - by : by - ay);
    return 32'({1'b0, dx * dx} + {1'b0, dy * dy}) <= R2U;
  endfunction

  // Candidate is the raster index (y high bits, x low bits); the other circle stays fixed
  always_comb begin
    cx     = cand[CW-1:0];
    cy     = cand[AW-1:CW];
    fx     = st == SCAN1 ? c2x : c1x;
    fy     = st == SCAN1 ? c2y : c1y;
    qx     = px[pi];
    qy     = py[pi];
    hit    = covers(qx, qy, cx, cy) | ((st == SCAN2 || pass != 4'd0) && covers(qx, qy, fx, fy));
    last_p = pi == PW'(N - 1);
    tot    = acc + SW'(hit);
    upd    = last_p && (!bv || tot > best);
  end

  // Job sequencer: load points, alternate scans, decide on another pass, publish result
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st       <= LOAD;
      for (int i = 0; i < N; i++) begin
        px[i] <= '0;
        py[i] <= '0;
      end
      k        <= '0;
      pi       <= '0;
      cand     <= '0;
      bc       <= '0;
      acc      <= '0;
      best     <= '0;
      sc       <= '0;
      prev     <= '0;
      bv       <= 1'b0;
      fin      <= 1'b0;
      c1x      <= '0;
      c1y      <= '0;
      c2x      <= '0;
      c2y      <= '0;
      pass     <= '0;
      IN_READY <= 1'b1;
      C1X      <= '0;
      C1Y      <= '0;
      C2X      <= '0;
      C2Y      <= '0;
      COVER    <= '0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (st)
        LOAD: if (IN_VALID && IN_READY) begin
          px[k] <= X;
          py[k] <= Y;
          if (k == PW'(N - 1)) begin
            k        <= '0;
            st       <= SCAN1;
            IN_READY <= 1'b0;
            c1x      <= '0;
            c1y      <= '0;
            c2x      <= '0;
            c2y      <= '0;
            pass     <= '0;
            prev     <= '0;
            sc       <= '0;
            pi       <= '0;
            cand     <= '0;
            acc      <= '0;
            bv       <= 1'b0;
            fin      <= 1'b0;
          end else begin
            k <= k + 1'b1;
          end
        end
        SCAN1, SCAN2: if (!fin) begin
          pi  <= last_p ? '0 : pi + 1'b1;
          acc <= last_p ? '0 : tot;
          if (last_p) begin
            cand <= cand + 1'b1;
            fin  <= &cand;
          end
          if (upd) begin
            best <= tot;
            bc   <= cand;
            bv   <= 1'b1;
          end
        end else begin
          if (st == SCAN1) begin
            c1x <= bc[CW-1:0];
            c1y <= bc[AW-1:CW];
          end else begin
            c2x <= bc[CW-1:0];
            c2y <= bc[AW-1:CW];
          end
          sc  <= best;
          fin <= 1'b0;
          bv  <= 1'b0;
`ifdef LASER_EARLY_EXIT_EN
          st  <= best == SW'(N) ? OUT : (st == SCAN1 ? SCAN2 : CHECK);
`else
          st  <= st == SCAN1 ? SCAN2 : CHECK;
`endif
        end
        CHECK: begin
          pass <= pass + 4'd1;
          prev <= sc;
          st   <= (sc <= prev || pass == 4'(MAX_ITER - 1)) ? OUT : SCAN1;
        end
        OUT: begin
          C1X      <= c1x;
          C1Y      <= c1y;
          C2X      <= c2x;
          C2Y      <= c2y;
          COVER    <= sc;
          DONE     <= 1'b1;
          IN_READY <= 1'b1;
          st       <= LOAD;
        end
        default: st <= LOAD;
      endcase
    end
  end
endmodule
